serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH clocks, one full-subtractor step per cycle.
- It is the subtraction-direction counterpart of the team's half-adder datapath, and it uses a single borrow flop in place of a carry.
- Operands are taken in on a valid/ready request port, and the result leaves on a valid/ready response port.
- It sits between the operand source and the result consumer in the arithmetic test datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  reset. Asynchronous, active-low.
start_valid  input  1  source presents a valid operand pair.
start_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  minuend, sampled on the accept edge only.
b  input  WIDTH  subtrahend, sampled on the accept edge only.
diff_valid  output  1  result available.
diff_ready  input  1  consumer accepts the result.
diff  output  WIDTH  a - b modulo 2^WIDTH.
borrow_out  output  1  1 when a < b (unsigned).
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, start_ready=1, diff_valid=0, diff=0, borrow_out=0, busy=0.
  - Operand shift registers, bit counter and borrow flop are cleared.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - Accept edge is a rising edge with start_valid & start_ready.
  - On accept: load a_sh=a, b_sh=b, borrow=0, cnt=0, result register cleared, go to SHIFT.
  - a and b are ignored on all other edges.
- SHIFT, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - d is shifted into the result from the MSB side (result = {d, result[WIDTH-1:1]}); a_sh and b_sh shift right; cnt increments.
  - When cnt==WIDTH-1 on this edge, go to DONE.
  - start_ready=0 throughout.
- DONE:
  - diff_valid=1; diff and borrow_out hold the final result and final borrow.
  - Both stay stable while diff_ready=0, indefinitely.
  - Edge with diff_ready=1: go to IDLE and drop diff_valid.
  - diff and borrow_out keep their last values in IDLE until the next accept.
- Latency: diff_valid is high after exactly WIDTH rising edges following the accept edge, i.e. WIDTH+1 edges including the accept edge.
- Throughput: one operation per WIDTH+2 cycles with diff_ready tied high. The result handshake edge and the next accept edge are distinct; start_ready rises the cycle after the handshake.
- start_valid asserted while busy: no effect, nothing queued. The source must hold start_valid until it sees start_ready.
- diff_ready asserted outside DONE: ignored.
- Counter width is clog2(WIDTH)+1 bits; the counter never wraps in normal operation.
- Arithmetic: unsigned modulo 2^WIDTH.
  - diff equals (a - b) mod 2^WIDTH.
  - borrow_out equals (a < b).
  - Equal operands give diff=0 and borrow_out=0.

Test Plan:
1. Reset, then a=200, b=55 → diff=145, borrow_out=0; diff_valid rises exactly 8 edges after the accept edge.
2. a=55, b=200 → diff=111, borrow_out=1. a=0, b=1 → diff=255, borrow_out=1. a=b=8'h5A → diff=0, borrow_out=0.
3. Backpressure: hold diff_ready=0 for 5 cycles in DONE → diff, borrow_out and diff_valid stay stable and start_ready=0. Pulse start_valid with a=9, b=3 during this window → ignored; the original result is delivered.
4. Back-to-back with diff_ready=1 and start_valid=1 throughout: 10-3 then 3-10 → results 7/0 then 249/1; accept edges are 10 cycles apart.
5. Reset mid-operation: assert rst_n=0 at the 4th SHIFT edge of 100-1 → all outputs are at reset values immediately. After release, 100-1 → 99, borrow_out=0, with no residue from the aborted operation.
6. WIDTH=16 instance: a=16'h0000, b=16'hFFFF → diff=16'h0001, borrow_out=1, latency 16 edges after accept. Random sweep of 500 pairs matches the reference model.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b, one full-subtractor step per clock,
// valid/ready on both the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             diff_valid,
    input  logic             diff_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0] cnt;
    logic borrow, d, borrow_nx, accept, last;
    always_comb begin
        d           = a_sh[0] ^ b_sh[0] ^ borrow;
        borrow_nx   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        start_ready = state == IDLE;
        diff_valid  = state == DONE;
        busy        = state != IDLE;
        accept      = start_ready & start_valid;
        last        = cnt == CW'(WIDTH - 1);
        state_nx    = state;
        if (accept) state_nx = SHIFT;
        else if (state == SHIFT && last) state_nx = DONE;
        else if (state == DONE && diff_ready) state_nx = IDLE;
    end
    // borrow flop doubles as borrow_out: it is final once SHIFT ends and cleared on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                res    <= '0;
                cnt    <= '0;
                borrow <= 1'b0;
            end else if (state == SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res    <= {d, res[WIDTH-1:1]};
                cnt    <= cnt + 1'b1;
                borrow <= borrow_nx;
            end
        end
    end
    assign diff       = res;
    assign borrow_out = borrow;
endmodule
